// File: rtl/snes_mem_pkg.sv
// snes_mem_pkg: shared types and constants for the cartridge ROM port arbiter
package snes_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_COP = 1'b1;

    localparam int DEF_RD_LAT = 3;

endpackage

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: serialises CPU and coprocessor reads onto the single ROM port, CPU first
module rom_port_arbiter
    import snes_mem_pkg::*;
#(
    parameter int AW     = 24,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_word,
    output logic          cpu_ack,
    output logic [15:0]   cpu_q,
    input  logic          cop_req,
    input  logic [AW-1:0] cop_addr,
    input  logic          cop_word,
    output logic          cop_ack,
    output logic [15:0]   cop_q,
    output logic [AW-1:0] rom_addr,
    output logic          rom_ce_n,
    output logic          rom_oe_n,
    output logic          rom_word,
    input  logic [15:0]   rom_q,
    output logic          busy,
    output logic          grant_cop
);

    arb_state_t    state_q;
    logic [2:0]    cnt_q;
    logic          owner_q;
    logic          ce_n_q;
    logic [AW-1:0] rom_addr_q;
    logic          rom_word_q;
    logic          cpu_ack_q;
    logic          cop_ack_q;
    logic [15:0]   cpu_q_q;
    logic [15:0]   cop_q_q;

    // Grant in IDLE, hold the ROM enabled for RD_LAT cycles, capture on the last one, ack in DONE
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            owner_q    <= OWNER_CPU;
            ce_n_q     <= 1'b1;
            rom_addr_q <= '0;
            rom_word_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cop_ack_q  <= 1'b0;
            cpu_q_q    <= 16'h0000;
            cop_q_q    <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || cop_req) begin
                        state_q    <= ACCESS;
                        owner_q    <= cpu_req ? OWNER_CPU : OWNER_COP;
                        rom_addr_q <= cpu_req ? cpu_addr : cop_addr;
                        rom_word_q <= cpu_req ? cpu_word : cop_word;
                        ce_n_q     <= 1'b0;
                        cnt_q      <= 3'(RD_LAT - 1);
                    end
                end
                ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                        ce_n_q  <= 1'b1;
                        if (owner_q == OWNER_COP) begin
                            cop_q_q   <= rom_q;
                            cop_ack_q <= 1'b1;
                        end else begin
                            cpu_q_q   <= rom_q;
                            cpu_ack_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cpu_ack_q <= 1'b0;
                    cop_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_q     = cpu_q_q;
    assign cop_ack   = cop_ack_q;
    assign cop_q     = cop_q_q;
    assign rom_addr  = rom_addr_q;
    assign rom_ce_n  = ce_n_q;
    assign rom_oe_n  = ce_n_q;
    assign rom_word  = rom_word_q;
    assign busy      = (state_q != IDLE);
    assign grant_cop = owner_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed scoreboard bench for the ROM port arbiter (default and RD_LAT=1 builds)
module tb_rom_port_arbiter;

    typedef struct {
        logic        owner;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_word = 1'b0, cop_req = 1'b0, cop_word = 1'b0;
    logic [23:0] cpu_addr = '0, cop_addr = '0;
    logic [15:0] rom_q = 16'hDEAD;
    logic        cpu_ack, cop_ack, rom_ce_n, rom_oe_n, rom_word, busy, grant_cop;
    logic [15:0] cpu_q, cop_q;
    logic [23:0] rom_addr;

    logic        b_cpu_req = 1'b0, b_cpu_word = 1'b0, b_cop_req = 1'b0, b_cop_word = 1'b0;
    logic [23:0] b_cpu_addr = '0, b_cop_addr = '0;
    logic [15:0] b_rom_q = 16'h9999;
    logic        b_cpu_ack, b_cop_ack, b_rom_ce_n, b_rom_oe_n, b_rom_word, b_busy, b_grant_cop;
    logic [15:0] b_cpu_q, b_cop_q;
    logic [23:0] b_rom_addr;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    rom_port_arbiter #(.AW(24), .RD_LAT(3)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_word(cpu_word), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .cop_req(cop_req), .cop_addr(cop_addr), .cop_word(cop_word), .cop_ack(cop_ack), .cop_q(cop_q),
        .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_word(rom_word), .rom_q(rom_q),
        .busy(busy), .grant_cop(grant_cop)
    );

    rom_port_arbiter #(.AW(24), .RD_LAT(1)) dut_l1 (
        .mclk(mclk), .rst_n(rst_n),
        .cpu_req(b_cpu_req), .cpu_addr(b_cpu_addr), .cpu_word(b_cpu_word), .cpu_ack(b_cpu_ack), .cpu_q(b_cpu_q),
        .cop_req(b_cop_req), .cop_addr(b_cop_addr), .cop_word(b_cop_word), .cop_ack(b_cop_ack), .cop_q(b_cop_q),
        .rom_addr(b_rom_addr), .rom_ce_n(b_rom_ce_n), .rom_oe_n(b_rom_oe_n), .rom_word(b_rom_word), .rom_q(b_rom_q),
        .busy(b_busy), .grant_cop(b_grant_cop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // From the IDLE cycle where a request is sampled, run one default-latency access up to its ack cycle
    task automatic acc(input logic [23:0] addr, input logic word, input logic owner, input logic [15:0] d);
        tick();
        chk("acc_ce", rom_ce_n, 1'b0);
        chk("acc_oe", rom_oe_n, 1'b0);
        chk("acc_addr", rom_addr, addr);
        chk("acc_word", rom_word, word);
        chk("acc_grant", grant_cop, owner);
        chk("acc_busy", busy, 1'b1);
        tick();
        chk("acc_ce2", rom_ce_n, 1'b0);
        tick();
        chk("acc_ce3", rom_ce_n, 1'b0);
        rom_q = d;
        tick();
        rom_q = 16'hDEAD;
        chk("done_ce", rom_ce_n, 1'b1);
        chk("done_oe", rom_oe_n, 1'b1);
        chk("done_busy", busy, 1'b1);
    endtask

    // Scoreboard: every ack pops the oldest expectation and is matched on owner, data and cycle
    always @(negedge mclk) begin : mon
        exp_t e;
        if (rst_n && (cpu_ack || cop_ack)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, cpu_ack, cop_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", cop_ack, e.owner);
                chk("ack_single", cpu_ack & cop_ack, 1'b0);
                chk("ack_data", cop_ack ? cop_q : cpu_q, e.data);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_ce", rom_ce_n, 1'b1);
        chk("rst_oe", rom_oe_n, 1'b1);
        chk("rst_addr", rom_addr, 24'h0);
        chk("rst_word", rom_word, 1'b0);
        chk("rst_acks", {cpu_ack, cop_ack}, 2'b00);
        chk("rst_cpu_q", cpu_q, 16'h0);
        chk("rst_cop_q", cop_q, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_cop, 1'b0);
        chk("rst_l1_ce", b_rom_ce_n, 1'b1);
        rst_n = 1'b1;
        tick();

        // CPU word read
        cpu_addr = 24'h123456;
        cpu_word = 1'b1;
        cpu_req = 1'b1;
        sb.push_back('{1'b0, 16'hBEEF, cyc + 4});
        acc(24'h123456, 1'b1, 1'b0, 16'hBEEF);
        cpu_req = 1'b0;
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_ack", cpu_ack, 1'b0);
        chk("t1_hold_q", cpu_q, 16'hBEEF);

        // Simultaneous requests: CPU first, COP in the following slot
        cpu_addr = 24'h00FFEE;
        cpu_word = 1'b0;
        cop_addr = 24'h000100;
        cop_word = 1'b1;
        cpu_req = 1'b1;
        cop_req = 1'b1;
        sb.push_back('{1'b0, 16'hAAAA, cyc + 4});
        sb.push_back('{1'b1, 16'h1234, cyc + 9});
        acc(24'h00FFEE, 1'b0, 1'b0, 16'hAAAA);
        cpu_req = 1'b0;
        tick();
        chk("t2_idle_busy", busy, 1'b0);
        acc(24'h000100, 1'b1, 1'b1, 16'h1234);
        cop_req = 1'b0;
        chk("t2_cpu_q_untouched", cpu_q, 16'hAAAA);
        tick();
        chk("t2_grant_kept", grant_cop, 1'b1);

        // CPU arrives while a COP access is in flight
        cop_addr = 24'h0ABCDE;
        cop_word = 1'b0;
        cop_req = 1'b1;
        sb.push_back('{1'b1, 16'h5555, cyc + 4});
        sb.push_back('{1'b0, 16'h6666, cyc + 9});
        tick();
        cpu_addr = 24'h000042;
        cpu_word = 1'b1;
        cpu_req = 1'b1;
        chk("t3_cop_addr", rom_addr, 24'h0ABCDE);
        chk("t3_cop_grant", grant_cop, 1'b1);
        tick();
        chk("t3_not_preempt", rom_addr, 24'h0ABCDE);
        tick();
        rom_q = 16'h5555;
        tick();
        rom_q = 16'hDEAD;
        cop_req = 1'b0;
        chk("t3_cpu_q_untouched", cpu_q, 16'hAAAA);
        tick();
        acc(24'h000042, 1'b1, 1'b0, 16'h6666);
        cpu_req = 1'b0;
        chk("t3_cop_q_untouched", cop_q, 16'h5555);
        tick();

        // Reset in the second ACCESS cycle drops the transaction
        cpu_addr = 24'h777777;
        cpu_req = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t4_ce_async", rom_ce_n, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_addr", rom_addr, 24'h0);
        chk("t4_cpu_q", cpu_q, 16'h0);
        chk("t4_cop_q", cop_q, 16'h0);
        chk("t4_grant", grant_cop, 1'b0);
        cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t4_after_busy", busy, 1'b0);
        chk("t4_after_ce", rom_ce_n, 1'b1);

        // COP holds its request across the ack: a second access follows
        cop_addr = 24'h000300;
        cop_word = 1'b0;
        cop_req = 1'b1;
        sb.push_back('{1'b1, 16'h1111, cyc + 4});
        sb.push_back('{1'b1, 16'h2222, cyc + 9});
        acc(24'h000300, 1'b0, 1'b1, 16'h1111);
        tick();
        chk("t5_idle_busy", busy, 1'b0);
        acc(24'h000300, 1'b0, 1'b1, 16'h2222);
        cop_req = 1'b0;
        repeat (4) tick();
        chk("t5_quiet_busy", busy, 1'b0);

        // RD_LAT=1 build: ack two cycles after sampling, back-to-back every three
        b_cpu_addr = 24'h00ABCD;
        b_cpu_word = 1'b1;
        b_cpu_req = 1'b1;
        tick();
        chk("l1_ce", b_rom_ce_n, 1'b0);
        chk("l1_addr", b_rom_addr, 24'h00ABCD);
        b_rom_q = 16'h4321;
        tick();
        chk("l1_ack1", b_cpu_ack, 1'b1);
        chk("l1_q1", b_cpu_q, 16'h4321);
        chk("l1_done_ce", b_rom_ce_n, 1'b1);
        b_rom_q = 16'h9999;
        tick();
        chk("l1_idle_ack", b_cpu_ack, 1'b0);
        chk("l1_idle_busy", b_busy, 1'b0);
        tick();
        chk("l1_ce2", b_rom_ce_n, 1'b0);
        b_rom_q = 16'h5678;
        tick();
        chk("l1_ack2", b_cpu_ack, 1'b1);
        chk("l1_q2", b_cpu_q, 16'h5678);
        b_cpu_req = 1'b0;
        tick();
        tick();
        chk("l1_quiet_busy", b_busy, 1'b0);
        chk("l1_cop_q", b_cop_q, 16'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single cartridge ROM read port (`rom_addr`/`rom_q`) between two requesters: the CPU-side mapper path and a coprocessor fetch engine (GSU, SA-1, CX4, S-DD1). Each access is serialised through a small state machine and sequenced for a fixed memory read latency. The CPU has fixed priority, and an access already in flight is never pre-empted. The block sits between a mapper's address decode and the top-level ROM mux, replacing direct `rom_*` drive from the mapper.

## Interface

Parameters:
- `AW`, 24: ROM address width.
- `RD_LAT`, 3: clock cycles from `rom_ce_n` falling to valid `rom_q`; legal range 1..7.

Ports:
- `mclk`, in, 1: master clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cpu_req`, in, 1: CPU-path read request; level, held until `cpu_ack`.
- `cpu_addr`, in, AW: CPU read address; stable while `cpu_req` is high.
- `cpu_word`, in, 1: 1 = 16-bit read, 0 = byte read.
- `cpu_ack`, out, 1: one-cycle pulse; `cpu_q` is valid in the same cycle.
- `cpu_q`, out, 16: read data, registered and held until the next CPU ack.
- `cop_req`, `cop_addr`, `cop_word`, `cop_ack`, `cop_q`: same meanings and widths for the coprocessor.
- `rom_addr`, out, AW: ROM address, registered.
- `rom_ce_n`, out, 1: ROM chip enable, active low.
- `rom_oe_n`, out, 1: ROM output enable, active low; always equal to `rom_ce_n`.
- `rom_word`, out, 1: width flag forwarded from the granted requester.
- `rom_q`, in, 16: ROM read data.
- `busy`, out, 1: high in any state other than IDLE.
- `grant_cop`, out, 1: the current or last grant went to the coprocessor.

## Operation

- States:
  - IDLE → ACCESS when either request is high; the grant is decided and latched here.
  - ACCESS → DONE after `RD_LAT` cycles.
  - DONE → IDLE unconditionally.
- Arbitration:
  - Sampled only in IDLE.
  - `cpu_req` wins over `cop_req`; a request arriving outside IDLE waits.
- On grant: `rom_addr`, `rom_word` and the owner bit are latched. Requester inputs are ignored until the next IDLE.
- In ACCESS:
  - `rom_ce_n` = `rom_oe_n` = 0.
  - A 3-bit down-counter is loaded with `RD_LAT-1` on entry.
  - `rom_q` is captured into the owner's `*_q` register on the final ACCESS cycle (counter = 0).
- In DONE: the owner's `*_ack` = 1 and `rom_ce_n` = 1.
- Requester rule: the requester drops `*_req` on the edge that ends its ack cycle. If `*_req` is still high in the following IDLE, it is treated as a new request.
- Byte reads: `rom_q` is passed through unmodified; lane selection is the requester's job.
- The non-owner's `*_q` and `*_ack` are untouched.
- Reset values: state IDLE, `rom_ce_n`/`rom_oe_n` = 1, `rom_addr` = 0, `rom_word` = 0, both acks 0, both `*_q` = 0, `busy` = 0, `grant_cop` = 0.
- Reset mid-operation: the transaction is dropped, no ack is ever issued for it, and all outputs return to reset values asynchronously.

## Timing

- The request is sampled in IDLE cycle k.
- `rom_ce_n` is low for cycles k+1 .. k+`RD_LAT`.
- Ack is high in cycle k+`RD_LAT`+1; IDLE is re-entered at k+`RD_LAT`+2.
- Throughput: one access per `RD_LAT`+2 cycles (5 at the default).
- Worst-case CPU wait from `cpu_req` rising to ack is 2·(`RD_LAT`+2)−1 cycles, which occurs when a COP access has just been granted. This fits inside the shortest SNES bus cycle (6 mclk) only when `RD_LAT` ≤ 1; top-level integration checks this.
- No combinational path from any input to any output.

## Structure

- Shared package `snes_mem_pkg` holds:
  - the `arb_state_t` enum (IDLE, ACCESS, DONE);
  - `OWNER_CPU` = 0 and `OWNER_COP` = 1;
  - the default `RD_LAT`.
- Single flat module, no sub-modules: counter, owner bit and data registers are too small to split.

## Test plan

- CPU word read, `cpu_addr` = 0x123456, `rom_q` = 0xBEEF during ACCESS → `rom_addr` = 0x123456, `rom_word` = 1, `rom_ce_n` low for 3 cycles, then `cpu_ack` pulse with `cpu_q` = 0xBEEF at k+4.
- `cpu_req` and `cop_req` rise in the same cycle (COP addr 0x000100, data 0x1234) → CPU acked at k+4, COP granted at k+5 and acked at k+9 with `cop_q` = 0x1234, `grant_cop` = 1.
- `cpu_req` rises during COP ACCESS → COP completes unaffected, CPU granted in the next IDLE, `cpu_ack` 4 cycles after that grant.
- `rst_n` pulsed low in the 2nd ACCESS cycle → `rom_ce_n` = 1 immediately, no ack after release, state IDLE, both `*_q` = 0.
- `cop_req` held high across its ack → a second access to the same address starts in the next IDLE, giving two acks 5 cycles apart.
- `RD_LAT` = 1 build → ack at k+2, back-to-back CPU reads every 3 cycles.
